// File: rtl/dmem_pkg.sv
// dmem_pkg: shared definitions for the data-memory controller.
//   - access size encodings (SZ_B / SZ_H / SZ_W, SZ_R is the reserved code)
//   - FSM state encoding (IDLE / WAIT / DONE)
//   - log2() and lane_cnt() helpers used to size address fields
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  // Ceiling log2; log2(1) = 0.
  function automatic int log2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < v) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

  // Number of byte lanes in a data word.
  function automatic int lane_cnt(input int dw);
    return dw / 8;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: purely combinational byte-lane steering.
//   Store side: shifts right-aligned write data to the addressed lanes and
//   produces byte enables. Load side: shifts the addressed lanes down to
//   bit 0 and sign/zero extends to DATA_W. Also flags misaligned and
//   reserved-size requests. The offset is always masked to the natural
//   alignment (size 11 handled as word); whether a flagged request is
//   rejected is decided by the controller.
// Ports:
//   offset      in   byte offset within the data word
//   size        in   access size (byte/half/word/reserved)
//   is_unsigned in   1 = zero extend loads, 0 = sign extend
//   wdata       in   right-aligned store data
//   rword       in   raw array word for loads
//   wdata_sh    out  store data placed on its lanes
//   byte_en     out  per-lane write enables
//   rdata_ext   out  extracted and extended load data
//   misaligned  out  request is misaligned or uses the reserved size
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int LANES  = lane_cnt(DATA_W),
  localparam int OFF_W  = log2(LANES)
) (
  input  logic [OFF_W-1:0]  offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rword,
  output logic [DATA_W-1:0] wdata_sh,
  output logic [LANES-1:0]  byte_en,
  output logic [DATA_W-1:0] rdata_ext,
  output logic              misaligned
);

  logic [OFF_W-1:0]  aoff_s;
  logic [LANES-1:0]  be_base_s;
  logic [OFF_W+2:0]  shamt_s;
  logic [DATA_W-1:0] rsh_s;
  logic              sign_s;
  int                nbits_s;

  // Per-size alignment mask, lane pattern, significant width and misalign flag
  always_comb begin
    aoff_s     = offset;
    be_base_s  = LANES'(4'b1111);
    nbits_s    = 32'sd32;
    misaligned = 1'b0;
    case (size)
      SZ_B: begin
        be_base_s = LANES'(4'b0001);
        nbits_s   = 32'sd8;
      end
      SZ_H: begin
        aoff_s[0]  = 1'b0;
        be_base_s  = LANES'(4'b0011);
        nbits_s    = 32'sd16;
        misaligned = offset[0];
      end
      SZ_W: begin
        aoff_s[1:0] = 2'b00;
        misaligned  = (offset[1:0] != 2'b00);
      end
      default: begin
        // reserved size: steered like a word, always flagged
        aoff_s[1:0] = 2'b00;
        misaligned  = 1'b1;
      end
    endcase
  end

  assign shamt_s  = {aoff_s, 3'b000};
  assign byte_en  = be_base_s << aoff_s;
  assign wdata_sh = wdata << shamt_s;
  assign rsh_s    = rword >> shamt_s;

  // Pick the sign bit of the loaded quantity
  always_comb begin
    sign_s = 1'b0;
    if (is_unsigned) begin
      sign_s = 1'b0;
    end else begin
      case (size)
        SZ_B:    sign_s = rsh_s[7];
        SZ_H:    sign_s = rsh_s[15];
        default: sign_s = rsh_s[31];
      endcase
    end
  end

  // Keep the significant bits, fill the rest with the extension bit
  always_comb begin
    rdata_ext = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i < nbits_s) begin
        rdata_ext[i] = rsh_s[i];
      end else begin
        rdata_ext[i] = sign_s;
      end
    end
  end

endmodule

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: data-memory subsystem between the pipeline datapath and an
// internal byte-enabled storage array. Supports byte/half/word accesses,
// sign/zero-extended sub-word loads and WAIT_CYC extra wait states, with a
// stall handshake that holds the datapath while an access is outstanding.
// Build option: define DMEM_ALIGN_TRAP_EN to reject misaligned or
// reserved-size requests with an err pulse; otherwise such requests are
// aligned down and executed, and err stays 0.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   req_re/we     load / store request (store wins if both)
//   req_addr      byte address (upper bits alias)
//   req_size      00 byte, 01 half, 10 word, 11 reserved
//   req_unsigned  load zero-extend select
//   req_wdata     right-aligned store data
//   stall         datapath must hold the request
//   rvalid, rdata load completion pulse and held load data
//   wack          store committed pulse
//   err           rejected access pulse
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 32,
  parameter int DEPTH    = 1024,
  parameter int WAIT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_re,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              stall,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              wack,
  output logic              err
);

  localparam int LANES = lane_cnt(DATA_W);
  localparam int OFF_W = log2(LANES);
  localparam int IDX_W = log2(DEPTH);
  localparam int LA_W  = OFF_W + IDX_W;

  state_t            state_r;
  logic [3:0]        cnt_r;
  logic              we_r;
  logic [LA_W-1:0]   addr_r;
  logic [1:0]        size_r;
  logic              uns_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rvalid_r;
  logic              wack_r;
  logic              err_r;

  logic [DATA_W-1:0] mem_r [DEPTH];

  logic              req_s;
  logic              fire_s;
  logic              trap_s;
  logic              sel_we_s;
  logic [LA_W-1:0]   sel_addr_s;
  logic [1:0]        sel_size_s;
  logic              sel_uns_s;
  logic [DATA_W-1:0] sel_wdata_s;
  logic [IDX_W-1:0]  idx_s;
  logic [DATA_W-1:0] rword_s;
  logic [DATA_W-1:0] wdata_sh_s;
  logic [LANES-1:0]  byte_en_s;
  logic [DATA_W-1:0] ld_ext_s;
  logic              misal_s;

  assign req_s = req_re | req_we;

  generate
    if (ADDR_W > LA_W) begin : g_addr_hi
      logic unused_addr_hi_s;
      assign unused_addr_hi_s = ^req_addr[ADDR_W-1:LA_W];
    end
  endgenerate

  // In IDLE the live request drives the datapath so a zero-wait access can
  // complete at the next edge; afterwards the captured copy is used.
  always_comb begin
    if (state_r == IDLE) begin
      sel_we_s    = req_we;
      sel_addr_s  = req_addr[LA_W-1:0];
      sel_size_s  = req_size;
      sel_uns_s   = req_unsigned;
      sel_wdata_s = req_wdata;
    end else begin
      sel_we_s    = we_r;
      sel_addr_s  = addr_r;
      sel_size_s  = size_r;
      sel_uns_s   = uns_r;
      sel_wdata_s = wdata_r;
    end
  end

  assign idx_s   = sel_addr_s[OFF_W +: IDX_W];
  assign rword_s = mem_r[idx_s];

  dmem_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .offset      (sel_addr_s[OFF_W-1:0]),
    .size        (sel_size_s),
    .is_unsigned (sel_uns_s),
    .wdata       (sel_wdata_s),
    .rword       (rword_s),
    .wdata_sh    (wdata_sh_s),
    .byte_en     (byte_en_s),
    .rdata_ext   (ld_ext_s),
    .misaligned  (misal_s)
  );

`ifdef DMEM_ALIGN_TRAP_EN
  assign trap_s = misal_s;
`else
  logic unused_misal_s;
  assign unused_misal_s = misal_s;
  assign trap_s         = 1'b0;
`endif

  // fire_s marks the edge that moves the FSM into DONE
  assign fire_s = ((state_r == IDLE) && req_s && (WAIT_CYC == 0)) ||
                  ((state_r == WAIT) && (cnt_r == 4'd1));

  assign stall = ((state_r == IDLE) && req_s) || (state_r == WAIT);

  // Access FSM, wait counter, request capture and registered completion outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      we_r     <= 1'b0;
      addr_r   <= '0;
      size_r   <= 2'b00;
      uns_r    <= 1'b0;
      wdata_r  <= '0;
      rdata_r  <= '0;
      rvalid_r <= 1'b0;
      wack_r   <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_s) begin
            we_r    <= req_we;
            addr_r  <= req_addr[LA_W-1:0];
            size_r  <= req_size;
            uns_r   <= req_unsigned;
            wdata_r <= req_wdata;
            if (WAIT_CYC == 0) begin
              state_r <= DONE;
            end else begin
              cnt_r   <= 4'(WAIT_CYC);
              state_r <= WAIT;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r <= DONE;
          end else begin
            state_r <= WAIT;
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase

      // Completion pulses are registered so they are high during DONE
      rvalid_r <= 1'b0;
      wack_r   <= 1'b0;
      err_r    <= 1'b0;
      if (fire_s) begin
        if (trap_s) begin
          err_r <= 1'b1;
        end else if (sel_we_s) begin
          wack_r <= 1'b1;
        end else begin
          rvalid_r <= 1'b1;
          rdata_r  <= ld_ext_s;
        end
      end
    end
  end

  // Storage array write: enabled lanes commit at the edge that ends DONE
  always_ff @(posedge clk) begin
    if ((state_r == DONE) && we_r && !trap_s) begin
      for (int i = 0; i < LANES; i++) begin
        if (byte_en_s[i]) begin
          mem_r[idx_s][8*i +: 8] <= wdata_sh_s[8*i +: 8];
        end
      end
    end
  end

  assign rvalid = rvalid_r;
  assign rdata  = rdata_r;
  assign wack   = wack_r;
  assign err    = err_r;

endmodule
